multi_mod_dds: RTL

- Parametrised multi-mode digital modulator: phase-accumulator DDS carrier, symbol-rate timer, symbol handshake and ASK/FSK/BPSK/QPSK mapping in one block.
- Drives the DAC data bus in the 120 MHz domain.
- Fed by the baseband symbol generator through a valid/ready handshake.
- Mode and carrier frequencies are runtime-selectable; mode changes take effect only on symbol boundaries.

---
 rtl/multi_mod_dds.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/multi_mod_dds.sv
// Multi-mode DDS modulator: phase accumulator carrier, symbol timer with valid/ready
// intake, and ASK/FSK/BPSK/QPSK quadrant mapping onto a quarter-wave sine ROM.
module multi_mod_dds #(
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 8,
    parameter int OUT_W    = 12,
    parameter int DIV_W    = 16,
    parameter     LUT_FILE = "sin_qw.hex"
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] fcw0,
    input  logic [PHASE_W-1:0] fcw1,
    input  logic [DIV_W-1:0]   sym_div,
    input  logic [1:0]         sym_data,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic [OUT_W-1:0]   mod_data,
    output logic               mod_valid,
    output logic               sym_strobe,
    output logic               underrun
);

    typedef enum logic [1:0] {
        MODE_ASK  = 2'd0,
        MODE_FSK  = 2'd1,
        MODE_BPSK = 2'd2,
        MODE_QPSK = 2'd3
    } mode_e;

    localparam int     LUT_N       = 1 << LUT_AW;
    localparam int     MAG_W       = OUT_W - 1;
    localparam longint MAG_MAX     = (64'sd1 <<< MAG_W) - 64'sd1;
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Quarter-wave table built at elaboration from a Q30 Taylor series, so the
    // contents cannot drift from the amplitude/width parameters.
    function automatic logic [LUT_N*MAG_W-1:0] build_rom();
        logic [LUT_N*MAG_W-1:0] rom;
        longint x, term, s, val;
        rom = '0;
        for (int i = 0; i < LUT_N; i++) begin
            x    = (HALF_PI_Q30 * longint'(i)) / longint'(LUT_N - 1);
            term = x;
            s    = x;
            for (int k = 1; k <= 9; k++) begin
                term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
                s    = s + term;
            end
            val = (s * MAG_MAX + (64'sd1 <<< 29)) >>> 30;
            if (val > MAG_MAX) val = MAG_MAX;
            if (val < 0) val = 0;
            rom[i*MAG_W +: MAG_W] = val[MAG_W-1:0];
        end
        return rom;
    endfunction

    localparam logic [LUT_N*MAG_W-1:0] SIN_ROM = build_rom();

    function automatic logic [1:0] quad_offset(input mode_e m, input logic [1:0] s);
        logic [1:0] q;
        q = 2'd0;
        if (m == MODE_BPSK) begin
            q = s[0] ? 2'd2 : 2'd0;
        end else if (m == MODE_QPSK) begin
            case (s)
                2'b00:   q = 2'd0;
                2'b01:   q = 2'd1;
                2'b11:   q = 2'd2;
                default: q = 2'd3;
            endcase
        end
        return q;
    endfunction

    // Offset binary is two's complement with the sign bit inverted.
    function automatic logic [OUT_W-1:0] to_offset_binary(input logic [MAG_W-1:0] mag,
                                                          input logic neg, input logic gate);
        logic signed [OUT_W-1:0] s;
        s = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        if (gate) s = '0;
        return {~s[OUT_W-1], s[OUT_W-2:0]};
    endfunction

    logic [MAG_W-1:0] sin_rom [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_rom
        assign sin_rom[g] = SIN_ROM[g*MAG_W +: MAG_W];
    end

    logic               run;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_eff;
    logic               tick;
    logic               xfer;
    logic [1:0]         act_sym;
    mode_e              act_mode;
    logic               act_idle;
    logic [PHASE_W-1:0] step;
    logic [PHASE_W-1:0] acc_p1;
    logic [LUT_AW+1:0]  phase;
    logic [1:0]         quad;
    logic [LUT_AW-1:0]  addr_p2;
    logic               neg_p2, gate_p2;
    logic [MAG_W-1:0]   mag_p3;
    logic               neg_p3, gate_p3;
    logic               vld_p1, vld_p2, vld_p3;

    assign div_eff   = (sym_div == '0) ? DIV_W'(1) : sym_div;
    assign tick      = run && (cnt >= div_eff - DIV_W'(1));
    assign xfer      = tick && sym_valid;
    assign sym_ready = tick;
    assign step      = (act_mode == MODE_FSK && act_sym[0]) ? fcw1 : fcw0;
    assign phase     = acc_p1[PHASE_W-1 -: LUT_AW+2];
    assign quad      = phase[LUT_AW+1:LUT_AW] + quad_offset(act_mode, act_sym);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            cnt        <= '0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            act_sym    <= 2'd0;
            act_mode   <= MODE_ASK;
            act_idle   <= 1'b1;
        end else begin
            run        <= 1'b1;
            sym_strobe <= tick;
            underrun   <= tick && !sym_valid;
            if (tick)     cnt <= '0;
            else if (run) cnt <= cnt + DIV_W'(1);
            if (xfer) begin
                act_sym  <= sym_data;
                act_mode <= mode_e'(mode);
                act_idle <= 1'b0;
            end else if (tick) begin
                act_idle <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1    <= '0;
            vld_p1    <= 1'b0;
            addr_p2   <= '0;
            neg_p2    <= 1'b0;
            gate_p2   <= 1'b1;
            vld_p2    <= 1'b0;
            mag_p3    <= '0;
            neg_p3    <= 1'b0;
            gate_p3   <= 1'b1;
            vld_p3    <= 1'b0;
            mod_data  <= {1'b1, {(OUT_W-1){1'b0}}};
            mod_valid <= 1'b0;
        end else begin
            // S1: free-running phase accumulator
            acc_p1  <= acc_p1 + step;
            vld_p1  <= run;
            // S2: quadrant offset and ROM address fold
            addr_p2 <= quad[0] ? ~phase[LUT_AW-1:0] : phase[LUT_AW-1:0];
            neg_p2  <= quad[1];
            gate_p2 <= act_idle || (act_mode == MODE_ASK && !act_sym[0]);
            vld_p2  <= vld_p1;
            // S3: synchronous ROM read
            mag_p3  <= sin_rom[addr_p2];
            neg_p3  <= neg_p2;
            gate_p3 <= gate_p2;
            vld_p3  <= vld_p2;
            // S4: output sample
            mod_data  <= to_offset_binary(mag_p3, neg_p3, gate_p3);
            mod_valid <= vld_p3;
        end
    end

endmodule
